// File: rtl/tinker_pkg.sv
// Shared constants and types for the tinker instruction fetch path.
package tinker_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h2000;
    localparam int          INST_W           = 32;
    localparam int          PC_W             = 64;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    // Sequential instruction address; 64-bit wrap is intended.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/tinker_sync_fifo.sv
// Synchronous FIFO with async reset and a synchronous clear that wins over
// any read or write in the same cycle. Simultaneous read and write are legal
// when full or empty.
module tinker_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, do_rd, do_wr;

    assign full      = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full || do_rd);

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_rd};
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, tags returning words
// with their PC into a small queue, and discards in-flight responses that
// were made stale by a redirect.
//
// state | meaning
// RUN   | no stale responses in flight; every response is enqueued
// FLUSH | drop_cnt_q responses still to be discarded before live data
module tinker_fetch_unit
    import tinker_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [63:0]       imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [63:0]       inst_pc,
    output logic              flushing
);

    localparam int QCW   = $clog2(DEPTH) + 1;
    localparam int PAY_W = PC_W + INST_W;

    fetch_state_t      state_q;
    logic [PC_W-1:0]   fetch_pc_q, rsp_pc_q;
    logic [3:0]        live_out_q, drop_cnt_q;

    logic [QCW-1:0]    q_count;
    logic              q_empty;
    logic [PAY_W-1:0]  q_rd_data;

    logic [5:0]        occupancy;
    logic              can_issue, req_fire, rsp_drop, rsp_live;
    logic [3:0]        drop_load;
    logic [PC_W-1:0]   redirect_aligned;

    // Queue slots already spoken for include live requests still in flight,
    // so an issued request always has a slot waiting for its response.
    assign occupancy = 6'(q_count) + {2'b00, live_out_q};
    assign can_issue = (occupancy < 6'(DEPTH)) &&
                       ((live_out_q + drop_cnt_q) < 4'(MAX_OUT));

    // Gated by reset so the request line drops the instant reset asserts.
    assign imem_req_valid = can_issue && !reset;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_q != 4'd0));
    assign rsp_live = imem_rsp_valid && !rsp_drop;

    // Everything still owed by memory after this edge becomes stale: prior
    // live and stale requests, plus one accepted now, less one returning now.
    assign drop_load = live_out_q + drop_cnt_q + {3'b000, req_fire} - {3'b000, imem_rsp_valid};

    assign redirect_aligned = redirect_pc & ~64'd3;

    assign inst_valid = !q_empty;
    assign inst_pc    = q_rd_data[PAY_W-1 -: PC_W];
    assign inst_data  = q_rd_data[INST_W-1:0];
    assign flushing   = (state_q == FLUSH);

    tinker_sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (redirect_valid),
        .wr_en_i   (rsp_live),
        .wr_data_i ({rsp_pc_q, imem_rsp_data}),
        .rd_en_i   (inst_ready),
        .rd_data_o (q_rd_data),
        .empty_o   (q_empty),
        .count_o   (q_count)
    );

    // Fetch/response PCs, in-flight accounting and the RUN/FLUSH state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_out_q <= '0;
            drop_cnt_q <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_aligned;
            rsp_pc_q   <= redirect_aligned;
            live_out_q <= '0;
            drop_cnt_q <= drop_load;
            state_q    <= (drop_load != 4'd0) ? FLUSH : RUN;
        end else begin
            if (req_fire) fetch_pc_q <= pc_plus4(fetch_pc_q);
            if (rsp_live) rsp_pc_q   <= pc_plus4(rsp_pc_q);
            live_out_q <= live_out_q + {3'b000, req_fire} - {3'b000, rsp_live};
            case (state_q)
                RUN: begin
                end
                FLUSH: begin
                    if (imem_rsp_valid) begin
                        drop_cnt_q <= drop_cnt_q - 4'd1;
                        if (drop_cnt_q == 4'd1) state_q <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit with a one-cycle-latency memory model.
module tb_tinker_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        flushing;

    int checks = 0;
    int errors = 0;

    logic [63:0] pend [$];
    logic        mem_auto;
    logic        last_fire, last_deq;
    logic [63:0] last_fire_addr, last_deq_pc;
    logic [31:0] last_deq_data;

    always #5 clk = ~clk;

    tinker_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .flushing       (flushing)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // One clock: memory answers the oldest pending request, handshakes are
    // recorded before the edge, outputs are left to be sampled 1ns after it.
    task automatic tick();
        last_fire = 1'b0;
        last_deq  = 1'b0;
        if (mem_auto && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            last_fire      = 1'b1;
            last_fire_addr = imem_req_addr;
        end
        if (inst_valid && inst_ready) begin
            last_deq      = 1'b1;
            last_deq_pc   = inst_pc;
            last_deq_data = inst_data;
        end
        @(posedge clk);
        #1;
        if (last_fire) pend.push_back(last_fire_addr);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        mem_auto       = 1'b1;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        mem_auto       = 1'b1;
        pend.delete();
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
        checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL rst_flushing got %b exp 0", flushing); end
        checks++; if (imem_req_addr !== 64'h2000) begin errors++; $display("FAIL rst_addr got %h exp 2000", imem_req_addr); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
            errors++; $display("FAIL rel_first_req got v=%b a=%h exp v=1 a=2000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_req, exp_pc;
        int n_deq;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        exp_req = 64'h2000;
        exp_pc  = 64'h2000;
        n_deq   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_fire) begin
                checks++;
                if (last_fire_addr !== exp_req) begin errors++; $display("FAIL stream_req got %h exp %h", last_fire_addr, exp_req); end
                exp_req = exp_req + 64'd4;
            end
            if (last_deq) begin
                checks++;
                if (last_deq_pc !== exp_pc || last_deq_data !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL stream_inst got pc=%h d=%h exp pc=%h d=%h", last_deq_pc, last_deq_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                n_deq++;
            end
        end
        checks++; if (n_deq < 10) begin errors++; $display("FAIL stream_count got %0d exp >=10", n_deq); end
    endtask

    task automatic test_backpressure();
        int n_fire;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        n_fire = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_fire) n_fire++;
        end
        checks++; if (n_fire != 4) begin errors++; $display("FAIL bp_total got %0d exp 4", n_fire); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_low got %b exp 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h2000 || inst_data !== 32'hC0DE2000) begin
            errors++; $display("FAIL bp_head got v=%b pc=%h d=%h exp v=1 pc=2000 d=c0de2000", inst_valid, inst_pc, inst_data);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (!last_deq || last_deq_pc !== 64'h2000) begin errors++; $display("FAIL bp_deq got %b pc=%h exp 1 pc=2000", last_deq, last_deq_pc); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_resume got %b exp 1", imem_req_valid); end
        tick();
        checks++; if (!last_fire || last_fire_addr !== 64'h2010) begin errors++; $display("FAIL bp_next_req got %b a=%h exp 1 a=2010", last_fire, last_fire_addr); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_refull got %b exp 0", imem_req_valid); end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_auto       = 1'b0;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3001;
        tick();
        redirect_valid = 1'b0;
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL rd_flush0 got %b exp 1", flushing); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin
            errors++; $display("FAIL rd_addr got v=%b a=%h exp v=1 a=3000", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        mem_auto       = 1'b1;
        tick();
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL rd_flush1 got %b exp 1", flushing); end
        tick();
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL rd_flush2 got %b exp 1", flushing); end
        tick();
        checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL rd_flush3 got %b exp 0", flushing); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_no_stale got %b exp 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h3000 || inst_data !== 32'hC0DE3000) begin
            errors++; $display("FAIL rd_first got v=%b pc=%h d=%h exp v=1 pc=3000 d=c0de3000", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (3) tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h2000) begin
            errors++; $display("FAIL col_pre got v=%b pc=%h exp v=1 pc=2000", inst_valid, inst_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++; if (!last_fire || !imem_rsp_valid) begin errors++; $display("FAIL col_setup got fire=%b rsp=%b exp 1 1", last_fire, imem_rsp_valid); end
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL col_flush got %b exp 1", flushing); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL col_consumed got %b exp 0", inst_valid); end
        checks++; if (imem_req_addr !== 64'h4000) begin errors++; $display("FAIL col_addr got %h exp 4000", imem_req_addr); end
        tick();
        checks++; if (flushing !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL col_drain got flush=%b v=%b exp 0 0", flushing, inst_valid);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h4000 || inst_data !== 32'hC0DE4000) begin
            errors++; $display("FAIL col_first got v=%b pc=%h d=%h exp v=1 pc=4000 d=c0de4000", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
                errors++; $display("FAIL stall_hold%0d got v=%b a=%h exp v=1 a=2000", i, imem_req_valid, imem_req_addr);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5000;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h5000) begin
            errors++; $display("FAIL stall_redirect got v=%b a=%h exp v=1 a=5000", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        checks++; if (!last_fire || last_fire_addr !== 64'h5000) begin
            errors++; $display("FAIL stall_accept got %b a=%h exp 1 a=5000", last_fire, last_fire_addr);
        end
    endtask

    task automatic test_reset_mid();
        int n_deq;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (3) tick();
        mem_auto = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rm_pre got v=%b rv=%b exp 1 0", inst_valid, imem_req_valid);
        end
        #2;
        reset = 1'b1;
        imem_rsp_valid = 1'b0;
        pend.delete();
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || flushing !== 1'b0) begin
            errors++; $display("FAIL rm_async got v=%b rv=%b f=%b exp 0 0 0", inst_valid, imem_req_valid, flushing);
        end
        @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_auto   = 1'b1;
        inst_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
            errors++; $display("FAIL rm_first_req got v=%b a=%h exp v=1 a=2000", imem_req_valid, imem_req_addr);
        end
        n_deq = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_deq && n_deq == 0) begin
                checks++;
                if (last_deq_pc !== 64'h2000 || last_deq_data !== 32'hC0DE2000) begin
                    errors++; $display("FAIL rm_inst0 got pc=%h d=%h exp pc=2000 d=c0de2000", last_deq_pc, last_deq_data);
                end
            end else if (last_deq && n_deq == 1) begin
                checks++;
                if (last_deq_pc !== 64'h2004 || last_deq_data !== 32'hC0DE2004) begin
                    errors++; $display("FAIL rm_inst1 got pc=%h d=%h exp pc=2004 d=c0de2004", last_deq_pc, last_deq_data);
                end
            end
            if (last_deq) n_deq++;
        end
        checks++; if (n_deq < 2) begin errors++; $display("FAIL rm_deq_count got %0d exp >=2", n_deq); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collision();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tinker_fetch_unit.md
TINKER_FETCH_UNIT -- requirements
Module: tinker_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction queue entries; power of two, 2..16.
REQ-002 Parameter MAX_OUT, default 4, meaning maximum outstanding memory requests, 1..15.
REQ-003 Parameter RESET_PC, default 64'h2000, meaning fetch address after reset.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port imem_req_valid  output  1  fetch request present.
REQ-007 Port imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 Port imem_req_addr  output  64  byte address of requested instruction.
REQ-009 Port imem_rsp_valid  input  1  response data valid; in request order; never back-pressured.
REQ-010 Port imem_rsp_data  input  32  instruction word.
REQ-011 Port redirect_valid  input  1  core-supplied new PC (branch, call, ret).
REQ-012 Port redirect_pc  input  64  redirect target.
REQ-013 Port inst_valid  output  1  queue head holds an instruction.
REQ-014 Port inst_ready  input  1  core consumes head this cycle.
REQ-015 Port inst_data  output  32  head instruction word.
REQ-016 Port inst_pc  output  64  byte address of head instruction.
REQ-017 Port flushing  output  1  high while stale responses are still being discarded.

Function
REQ-018 Request handshake: transfer when imem_req_valid && imem_req_ready; imem_req_addr SHALL hold stable while valid && !ready, except on redirect.
REQ-019 imem_req_valid SHALL be high iff queue_count + live_out < DEPTH and live_out + drop_cnt < MAX_OUT, where live_out = outstanding non-stale requests.
REQ-020 fetch_pc SHALL increment by 4 (64-bit wrap) on each accepted request.
REQ-021 Each live response SHALL be written to the queue tagged with rsp_pc, then rsp_pc += 4; entry visible on inst_valid the following cycle (no bypass).
REQ-022 Output handshake: dequeue when inst_valid && inst_ready; simultaneous enqueue and dequeue at full or empty SHALL be legal, count unchanged when full.
REQ-023 Redirect: fetch_pc and rsp_pc SHALL load {redirect_pc[63:2],2'b00}; queue SHALL be emptied; drop_cnt SHALL load all outstanding requests, including any accepted in the same cycle, minus one if a response arrives in the same cycle.
REQ-024 A response arriving in the redirect cycle SHALL be discarded; a request accepted in the redirect cycle SHALL be counted stale.
REQ-025 Requests SHALL be issued from the cycle after redirect, using the new fetch_pc, including in FLUSH state.
REQ-026 Responses while drop_cnt > 0 SHALL be discarded, decrementing drop_cnt.
REQ-027 FSM states RUN and FLUSH: RUN->FLUSH on redirect with nonzero drop_cnt load; FLUSH->RUN when drop_cnt reaches 0; a redirect in FLUSH reloads drop_cnt and stays in FLUSH; flushing = (state == FLUSH).
REQ-028 An inst handshake coinciding with redirect SHALL count as consumed; inst_valid SHALL be 0 the next cycle.

Reset
REQ-029 On reset assertion, asynchronously: imem_req_valid=0, inst_valid=0, flushing=0, queue empty, live_out=0, drop_cnt=0, state RUN, fetch_pc=rsp_pc=RESET_PC.
REQ-030 Reset mid-operation SHALL abandon outstanding requests without discard accounting; the memory side is reset by the same signal.
REQ-031 First request (addr RESET_PC) SHALL assert in the first cycle after reset deasserts.

Structure
REQ-032 Package tinker_pkg SHALL hold the RESET_PC default, the 32-bit instruction width constant, and the fetch_state_t enum {RUN, FLUSH}.
REQ-033 Queue SHALL be sub-module tinker_sync_fifo (parametrised width/depth, {pc,inst} payload, synchronous clear input).

Verification
REQ-034 Reset release, ready=1, 1-cycle memory -> requests 0x2000, 0x2004, 0x2008...; inst_pc sequence identical, data matches memory.
REQ-035 inst_ready=0, DEPTH=4 -> at most 4 requests total, imem_req_valid low once queue_count + live_out = 4, resumes one cycle after one dequeue.
REQ-036 3 requests outstanding, redirect_pc=0x3001 -> next request addr 0x3000, flushing=1 for 3 responses, all three discarded, first inst_pc 0x3000.
REQ-037 Redirect in the same cycle as a response and request acceptance -> that response dropped, accepted request counted stale, drop_cnt correct.
REQ-038 imem_req_ready=0 for 5 cycles -> imem_req_addr stable at 0x2000 throughout; redirect during the stall changes it to the target next cycle.
REQ-039 Reset asserted with full queue and 2 outstanding -> inst_valid=0 immediately, first request 0x2000 after release, no stale data delivered.
